conv_window_sched: RTL and testbench

//  Scheduler for the 3x3 convolution window over the binary input-image RAM.

---
 rtl/conv_window_sched_if.sv | 27 ++
 rtl/conv_window_sched.sv | 161 ++++++++++++++++
 tb/tb_conv_window_sched.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/conv_window_sched_if.sv
// Handshake bundle between the RX write path, the tap scheduler and cnn_core.
// master is the scheduler side; slave is the RAM/core environment side.
interface conv_window_sched_if #(
    parameter int ADDR_W = 10
);
    logic              frame_clr;
    logic [ADDR_W-1:0] wr_addr;
    logic              core_bsy;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              win_strt;
    logic              win_vld;
    logic [3:0]        win_tap;
    logic              win_last;
    logic              busy;
    logic              frame_done;

    modport master (
        input  frame_clr, wr_addr, core_bsy,
        output rd_en, rd_addr, win_strt, win_vld, win_tap, win_last, busy, frame_done
    );

    modport slave (
        output frame_clr, wr_addr, core_bsy,
        input  rd_en, rd_addr, win_strt, win_vld, win_tap, win_last, busy, frame_done
    );
endinterface

// File: rtl/conv_window_sched.sv
// Walks 3x3 windows over the bit-wide input RAM, issuing 9 tap reads per window
// once the window's bottom-right pixel has been written and the core is idle.
module conv_window_sched #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                rst,
    conv_window_sched_if.master bus
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [ADDR_W-1:0] ANCHOR_INIT = ADDR_W'(2 * IMG_W + 2);

    typedef enum logic [1:0] {IDLE, TAP, ADV, DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        k_q, k_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] anchor_q, anchor_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              win_vld_q, win_vld_d;
    logic              win_strt_q, win_strt_d;
    logic              win_last_q, win_last_d;
    logic [3:0]        win_tap_q, win_tap_d;
    logic              frame_done_q, frame_done_d;

    logic [3:0]        tap_sel;
    logic [ADDR_W-1:0] tap_off;
    logic [ADDR_W-1:0] tap_addr;

    // Offset back from the anchor for the tap about to be put on rd_addr.
    always_comb begin
        tap_sel = (state_q == TAP) ? k_q + 4'd1 : 4'd0;
        case (tap_sel)
            4'd0:    tap_off = ADDR_W'(2 * IMG_W + 2);
            4'd1:    tap_off = ADDR_W'(2 * IMG_W + 1);
            4'd2:    tap_off = ADDR_W'(2 * IMG_W);
            4'd3:    tap_off = ADDR_W'(IMG_W + 2);
            4'd4:    tap_off = ADDR_W'(IMG_W + 1);
            4'd5:    tap_off = ADDR_W'(IMG_W);
            4'd6:    tap_off = ADDR_W'(2);
            4'd7:    tap_off = ADDR_W'(1);
            default: tap_off = '0;
        endcase
        tap_addr = anchor_q - tap_off;
    end

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        col_d        = col_q;
        row_d        = row_q;
        anchor_d     = anchor_q;
        rd_en_d      = 1'b0;
        rd_addr_d    = '0;
        frame_done_d = 1'b0;
        // RAM data lags the read strobe by one cycle, so the tap tags follow rd_en.
        win_vld_d    = rd_en_q;
        win_strt_d   = rd_en_q && (k_q == 4'd0);
        win_last_d   = rd_en_q && (k_q == 4'd8);
        win_tap_d    = rd_en_q ? k_q : 4'd0;

        case (state_q)
            IDLE: begin
                if ((anchor_q < bus.wr_addr) && !bus.core_bsy) begin
                    state_d   = TAP;
                    k_d       = 4'd0;
                    rd_en_d   = 1'b1;
                    rd_addr_d = tap_addr;
                end
            end
            TAP: begin
                if (k_q == 4'd8) begin
                    state_d = ADV;
                    k_d     = 4'd0;
                end else begin
                    k_d       = k_q + 4'd1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = tap_addr;
                end
            end
            ADV: begin
                state_d = IDLE;
                if (col_q == COL_W'(IMG_W - 3)) begin
                    // Last window of the frame leaves the anchor in range.
                    if (row_q == ROW_W'(IMG_H - 3)) begin
                        state_d      = DONE;
                        frame_done_d = 1'b1;
                    end else begin
                        col_d    = '0;
                        row_d    = row_q + 1'b1;
                        anchor_d = anchor_q + ADDR_W'(3);
                    end
                end else begin
                    col_d    = col_q + 1'b1;
                    anchor_d = anchor_q + ADDR_W'(1);
                end
            end
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase

        if (bus.frame_clr) begin
            state_d      = IDLE;
            k_d          = 4'd0;
            col_d        = '0;
            row_d        = '0;
            anchor_d     = ANCHOR_INIT;
            rd_en_d      = 1'b0;
            rd_addr_d    = '0;
            frame_done_d = 1'b0;
            win_vld_d    = 1'b0;
            win_strt_d   = 1'b0;
            win_last_d   = 1'b0;
            win_tap_d    = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            k_q          <= 4'd0;
            col_q        <= '0;
            row_q        <= '0;
            anchor_q     <= ANCHOR_INIT;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            win_vld_q    <= 1'b0;
            win_strt_q   <= 1'b0;
            win_last_q   <= 1'b0;
            win_tap_q    <= 4'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            col_q        <= col_d;
            row_q        <= row_d;
            anchor_q     <= anchor_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            win_vld_q    <= win_vld_d;
            win_strt_q   <= win_strt_d;
            win_last_q   <= win_last_d;
            win_tap_q    <= win_tap_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.rd_en      = rd_en_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.win_vld    = win_vld_q;
    assign bus.win_strt   = win_strt_q;
    assign bus.win_last   = win_last_q;
    assign bus.win_tap    = win_tap_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = (state_q == TAP) || (state_q == ADV);
endmodule

// File: tb/tb_conv_window_sched.sv
// Directed bench for conv_window_sched on a 28x28 frame: first window, reset and
// frame_clr mid-burst, core_bsy gating, row wrap and a complete frame.
module tb_conv_window_sched;
    localparam int W = 28;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    conv_window_sched_if #(.ADDR_W(10)) bus ();

    conv_window_sched #(.IMG_W(28), .IMG_H(28), .ADDR_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic clr, input int wr, input logic bsy);
        rst           = r;
        bus.frame_clr = clr;
        bus.wr_addr   = 10'(wr);
        bus.core_bsy  = bsy;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Expected address of tap k for a window whose bottom-right pixel is anchor.
    function automatic int tapAddr(input int anchor, input int k);
        return anchor - (2 - k / 3) * W - (2 - k % 3);
    endfunction

    // Launch is expected on the first edge; samples taps then ADV then IDLE.
    task automatic expectBurst(input int anchor);
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            checkOutput($sformatf("a%0d_rd_en_%0d", anchor, i), int'(bus.rd_en), (i < 9) ? 1 : 0);
            if (i < 9)
                checkOutput($sformatf("a%0d_rd_addr_%0d", anchor, i), int'(bus.rd_addr), tapAddr(anchor, i));
            checkOutput($sformatf("a%0d_vld_%0d", anchor, i), int'(bus.win_vld), (i >= 1 && i <= 9) ? 1 : 0);
            if (i >= 1 && i <= 9)
                checkOutput($sformatf("a%0d_tap_%0d", anchor, i), int'(bus.win_tap), i - 1);
            checkOutput($sformatf("a%0d_strt_%0d", anchor, i), int'(bus.win_strt), (i == 1) ? 1 : 0);
            checkOutput($sformatf("a%0d_last_%0d", anchor, i), int'(bus.win_last), (i == 9) ? 1 : 0);
            checkOutput($sformatf("a%0d_busy_%0d", anchor, i), int'(bus.busy), (i <= 9) ? 1 : 0);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rd_en"}, int'(bus.rd_en), 0);
        checkOutput({tag, "_rd_addr"}, int'(bus.rd_addr), 0);
        checkOutput({tag, "_vld"}, int'(bus.win_vld), 0);
        checkOutput({tag, "_strt"}, int'(bus.win_strt), 0);
        checkOutput({tag, "_last"}, int'(bus.win_last), 0);
        checkOutput({tag, "_tap"}, int'(bus.win_tap), 0);
        checkOutput({tag, "_busy"}, int'(bus.busy), 0);
        checkOutput({tag, "_done"}, int'(bus.frame_done), 0);
    endtask

    initial begin
        int wins;
        int done_cnt;
        int last_addr;
        int post;

        // Reset state
        applyStimulus(1'b1, 1'b0, 0, 1'b0);
        repeat (2) @(negedge clk);
        checkAllZero("reset");

        // First window needs pixel 58 written
        applyStimulus(1'b0, 1'b0, 58, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("not_ready_%0d", i), int'(bus.rd_en), 0);
        end
        applyStimulus(1'b0, 1'b0, 59, 1'b0);
        expectBurst(58);

        // Reset in the middle of the anchor-59 burst
        applyStimulus(1'b0, 1'b0, 60, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("pre_rst_addr_%0d", i), int'(bus.rd_addr), tapAddr(59, i));
        end
        applyStimulus(1'b1, 1'b0, 60, 1'b0);
        @(negedge clk);
        checkAllZero("mid_rst");
        applyStimulus(1'b0, 1'b0, 59, 1'b0);
        expectBurst(58);

        // frame_clr during tap 4 of the anchor-59 burst
        applyStimulus(1'b0, 1'b0, 60, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("pre_clr_addr_%0d", i), int'(bus.rd_addr), tapAddr(59, i));
        end
        applyStimulus(1'b0, 1'b1, 60, 1'b0);
        @(negedge clk);
        checkOutput("clr_rd_en", int'(bus.rd_en), 0);
        checkOutput("clr_vld", int'(bus.win_vld), 0);
        checkOutput("clr_busy", int'(bus.busy), 0);
        applyStimulus(1'b0, 1'b0, 60, 1'b0);
        expectBurst(58);

        // core_bsy holds off the anchor-59 window
        applyStimulus(1'b0, 1'b0, 784, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("core_bsy_hold_%0d", i), int'(bus.rd_en), 0);
        end
        applyStimulus(1'b0, 1'b0, 784, 1'b0);
        // Back-to-back bursts through the end of row 0 and the wrap to anchor 86
        for (int a = 59; a <= 83; a++)
            expectBurst(a);
        expectBurst(86);

        // Remainder of the frame: 676 - 27 windows
        wins = 0;
        done_cnt = 0;
        last_addr = -1;
        post = 0;
        for (int c = 0; c < 8200 && !(done_cnt > 0 && post >= 20); c++) begin
            @(negedge clk);
            if (bus.rd_en) last_addr = int'(bus.rd_addr);
            if (bus.win_last) wins++;
            if (bus.frame_done) done_cnt++;
            if (done_cnt > 0) post++;
        end
        checkOutput("frame_windows", wins, 649);
        checkOutput("frame_last_addr", last_addr, 783);
        checkOutput("frame_done_pulses", done_cnt, 1);
        checkOutput("done_hold_rd_en", int'(bus.rd_en), 0);
        checkOutput("done_hold_busy", int'(bus.busy), 0);
        checkOutput("done_hold_pulse", int'(bus.frame_done), 0);

        // Re-arm for the next frame
        applyStimulus(1'b0, 1'b1, 784, 1'b0);
        @(negedge clk);
        checkOutput("rearm_rd_en", int'(bus.rd_en), 0);
        checkOutput("rearm_done", int'(bus.frame_done), 0);
        applyStimulus(1'b0, 1'b0, 784, 1'b0);
        expectBurst(58);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
